// File: rtl/ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ccip_host_mem_responder (with helper ccip_hmr_rspq)
// Purpose  : Host-side memory responder for AFU bring-up benches. Accepts
//            line-granular read (c0Tx) and write (c1Tx) requests, keeps a
//            line-addressed backing memory, and returns in-order read
//            responses and write acks after a fixed minimum latency.
//            Provides almost-full back-pressure, a response hold input,
//            and sticky overflow flags.
// Ports    : clk, reset (sync, active-high)
//            rd_req_valid/addr/mdata            read request
//            wr_req_valid/addr/mdata/data       write request
//            rsp_hold                           suppress all responses
//            rd_almfull, wr_almfull             registered back-pressure
//            rd_rsp_valid/mdata/data            read response
//            wr_rsp_valid/mdata                 write ack
//            rd_ovf, wr_ovf                     sticky request-dropped flags
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Response queue: FIFO of {payload, stamp} with latency-gated head pop.
// Ports: stamp_i (free-running stamp), push_i/push_payload_i (request),
//        hold_i (block pops), accept_o (push taken), pop_o (head leaves),
//        head_payload_o, almfull_o (registered).
// ----------------------------------------------------------------------------
module ccip_hmr_rspq #(
    parameter int PAYLOAD_W     = 8,
    parameter int QDEPTH        = 8,
    parameter int LATENCY       = 4,
    parameter int ALMFULL_SLACK = 2,
    parameter int STAMP_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [STAMP_W-1:0]   stamp_i,
    input  logic                 push_i,
    input  logic [PAYLOAD_W-1:0] push_payload_i,
    input  logic                 hold_i,
    output logic                 accept_o,
    output logic                 pop_o,
    output logic [PAYLOAD_W-1:0] head_payload_o,
    output logic                 almfull_o
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [STAMP_W-1:0] RIPE_AGE    = STAMP_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0]   ALMFULL_CNT = CNT_W'(QDEPTH - ALMFULL_SLACK);

    logic [PAYLOAD_W-1:0] payload_q     [QDEPTH];
    logic [STAMP_W-1:0]   entry_stamp_q [QDEPTH];
    logic [STAMP_W-1:0]   age           [QDEPTH];
    logic [QDEPTH-1:0]    ripe_q, ripe_d;
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 almfull_q;
    logic                 full;
    logic                 head_ok;

    // Stamps are modular, so an entry held back long enough would see its
    // age wrap below the threshold. The per-entry ripe bit latches the
    // moment the age first reaches LATENCY-1 and keeps the entry eligible.
    always_comb begin
        ripe_d = ripe_q;
        for (int i = 0; i < QDEPTH; i++) begin
            age[i]    = stamp_i - entry_stamp_q[i];
            ripe_d[i] = ripe_q[i] | (age[i] >= RIPE_AGE);
        end
        if (accept_o) begin
            ripe_d[tail_q] = 1'b0;
        end
    end

    assign full     = (count_q == FULL_CNT);
    assign head_ok  = (count_q != '0) && (ripe_q[head_q] || (age[head_q] >= RIPE_AGE));
    assign pop_o    = head_ok && !hold_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign accept_o = push_i && (!full || pop_o);
    assign count_d  = count_q + CNT_W'(accept_o) - CNT_W'(pop_o);

    assign head_payload_o = payload_q[head_q];
    assign almfull_o      = almfull_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ripe_q    <= '0;
            almfull_q <= 1'b0;
        end else begin
            if (accept_o) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_o) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q   <= count_d;
            ripe_q    <= ripe_d;
            almfull_q <= (count_d >= ALMFULL_CNT);
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (accept_o) begin
            payload_q[tail_q]     <= push_payload_i;
            entry_stamp_q[tail_q] <= stamp_i;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module ccip_host_mem_responder #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 512,
    parameter int MDATA_W       = 16,
    parameter int LATENCY       = 4,
    parameter int QDEPTH        = 8,
    parameter int ALMFULL_SLACK = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req_valid,
    input  logic [ADDR_W-1:0]  rd_req_addr,
    input  logic [MDATA_W-1:0] rd_req_mdata,
    input  logic               wr_req_valid,
    input  logic [ADDR_W-1:0]  wr_req_addr,
    input  logic [MDATA_W-1:0] wr_req_mdata,
    input  logic [DATA_W-1:0]  wr_req_data,
    input  logic               rsp_hold,
    output logic               rd_almfull,
    output logic               wr_almfull,
    output logic               rd_rsp_valid,
    output logic [MDATA_W-1:0] rd_rsp_mdata,
    output logic [DATA_W-1:0]  rd_rsp_data,
    output logic               wr_rsp_valid,
    output logic [MDATA_W-1:0] wr_rsp_mdata,
    output logic               rd_ovf,
    output logic               wr_ovf
);
    localparam int STAMP_W = $clog2(LATENCY) + 2;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic [STAMP_W-1:0] stamp_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               rd_accept, rd_pop;
    logic [MDATA_W-1:0] rd_head_mdata;
    logic [ADDR_W-1:0]  rd_head_addr;
    logic               wr_accept, wr_pop;
    logic [MDATA_W-1:0] wr_head_mdata;

    logic               rd_rsp_valid_q, wr_rsp_valid_q;
    logic [MDATA_W-1:0] rd_rsp_mdata_q, wr_rsp_mdata_q;
    logic [DATA_W-1:0]  rd_rsp_data_q;
    logic               rd_ovf_q, wr_ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + STAMP_W'(1);
        end
    end

    ccip_hmr_rspq #(
        .PAYLOAD_W     (MDATA_W + ADDR_W),
        .QDEPTH        (QDEPTH),
        .LATENCY       (LATENCY),
        .ALMFULL_SLACK (ALMFULL_SLACK),
        .STAMP_W       (STAMP_W)
    ) u_rd_q (
        .clk            (clk),
        .reset          (reset),
        .stamp_i        (stamp_q),
        .push_i         (rd_req_valid),
        .push_payload_i ({rd_req_mdata, rd_req_addr}),
        .hold_i         (rsp_hold),
        .accept_o       (rd_accept),
        .pop_o          (rd_pop),
        .head_payload_o ({rd_head_mdata, rd_head_addr}),
        .almfull_o      (rd_almfull)
    );

    ccip_hmr_rspq #(
        .PAYLOAD_W     (MDATA_W),
        .QDEPTH        (QDEPTH),
        .LATENCY       (LATENCY),
        .ALMFULL_SLACK (ALMFULL_SLACK),
        .STAMP_W       (STAMP_W)
    ) u_wr_q (
        .clk            (clk),
        .reset          (reset),
        .stamp_i        (stamp_q),
        .push_i         (wr_req_valid),
        .push_payload_i (wr_req_mdata),
        .hold_i         (rsp_hold),
        .accept_o       (wr_accept),
        .pop_o          (wr_pop),
        .head_payload_o (wr_head_mdata),
        .almfull_o      (wr_almfull)
    );

    // Memory keeps its contents across reset; dropped writes never land.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem_q[wr_req_addr] <= wr_req_data;
        end
    end

    // The read samples mem_q before this edge's write, which gives
    // read-before-write ordering for a same-cycle pop and write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_mdata_q <= '0;
            rd_rsp_data_q  <= '0;
            wr_rsp_valid_q <= 1'b0;
            wr_rsp_mdata_q <= '0;
            rd_ovf_q       <= 1'b0;
            wr_ovf_q       <= 1'b0;
        end else begin
            rd_rsp_valid_q <= rd_pop;
            wr_rsp_valid_q <= wr_pop;
            if (rd_pop) begin
                rd_rsp_mdata_q <= rd_head_mdata;
                rd_rsp_data_q  <= mem_q[rd_head_addr];
            end
            if (wr_pop) begin
                wr_rsp_mdata_q <= wr_head_mdata;
            end
            if (rd_req_valid && !rd_accept) begin
                rd_ovf_q <= 1'b1;
            end
            if (wr_req_valid && !wr_accept) begin
                wr_ovf_q <= 1'b1;
            end
        end
    end

    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_mdata = rd_rsp_mdata_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign wr_rsp_valid = wr_rsp_valid_q;
    assign wr_rsp_mdata = wr_rsp_mdata_q;
    assign rd_ovf       = rd_ovf_q;
    assign wr_ovf       = wr_ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_host_mem_responder
// Purpose  : Self-checking bench for ccip_host_mem_responder. A cycle-level
//            reference model (queues with absolute request cycles plus an
//            array memory) predicts every output each cycle; directed
//            scenarios add explicit latency/overflow/ordering checks, and a
//            randomized phase exercises mixed traffic, holds and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccip_host_mem_responder;
    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 512;
    localparam int MDATA_W       = 16;
    localparam int LATENCY       = 4;
    localparam int QDEPTH        = 8;
    localparam int ALMFULL_SLACK = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               rd_req_valid;
    logic [ADDR_W-1:0]  rd_req_addr;
    logic [MDATA_W-1:0] rd_req_mdata;
    logic               wr_req_valid;
    logic [ADDR_W-1:0]  wr_req_addr;
    logic [MDATA_W-1:0] wr_req_mdata;
    logic [DATA_W-1:0]  wr_req_data;
    logic               rsp_hold;
    logic               rd_almfull, wr_almfull;
    logic               rd_rsp_valid, wr_rsp_valid;
    logic [MDATA_W-1:0] rd_rsp_mdata, wr_rsp_mdata;
    logic [DATA_W-1:0]  rd_rsp_data;
    logic               rd_ovf, wr_ovf;

    always #5 clk = ~clk;

    ccip_host_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(MDATA_W),
        .LATENCY(LATENCY), .QDEPTH(QDEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_mdata (rd_req_mdata),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_mdata (wr_req_mdata),
        .wr_req_data  (wr_req_data),
        .rsp_hold     (rsp_hold),
        .rd_almfull   (rd_almfull),
        .wr_almfull   (wr_almfull),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_mdata (rd_rsp_mdata),
        .rd_rsp_data  (rd_rsp_data),
        .wr_rsp_valid (wr_rsp_valid),
        .wr_rsp_mdata (wr_rsp_mdata),
        .rd_ovf       (rd_ovf),
        .wr_ovf       (wr_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                         input logic [DATA_W-1:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: requests carry the cycle number they were accepted
    // in; the head may leave once LATENCY-1 cycles have passed and hold is
    // low. Outputs predicted here are those visible after each edge.
    // ------------------------------------------------------------------
    typedef struct {
        logic [MDATA_W-1:0] mdata;
        logic [ADDR_W-1:0]  addr;
        int                 t;
    } req_t;

    req_t               rq[$];
    req_t               wq[$];
    logic [DATA_W-1:0]  mmem [2**ADDR_W];
    int                 cyc = 0;
    logic               e_rd_v = 0, e_wr_v = 0, e_rd_af = 0, e_wr_af = 0;
    logic               e_rd_ovf = 0, e_wr_ovf = 0;
    logic [MDATA_W-1:0] e_rd_md = '0, e_wr_md = '0;
    logic [DATA_W-1:0]  e_rd_d = '0;

    always @(posedge clk) begin
        bit rpop, wpop;
        cyc++;
        if (reset) begin
            rq.delete();
            wq.delete();
            e_rd_v = 0; e_wr_v = 0; e_rd_md = '0; e_wr_md = '0; e_rd_d = '0;
            e_rd_af = 0; e_wr_af = 0; e_rd_ovf = 0; e_wr_ovf = 0;
        end else begin
            rpop = (rq.size() > 0) && ((cyc - rq[0].t) >= LATENCY - 1) && !rsp_hold;
            wpop = (wq.size() > 0) && ((cyc - wq[0].t) >= LATENCY - 1) && !rsp_hold;
            e_rd_v = rpop;
            e_wr_v = wpop;
            if (rpop) begin
                e_rd_md = rq[0].mdata;
                e_rd_d  = mmem[rq[0].addr];
                void'(rq.pop_front());
            end
            if (wpop) begin
                e_wr_md = wq[0].mdata;
                void'(wq.pop_front());
            end
            if (rd_req_valid) begin
                if (rq.size() < QDEPTH) rq.push_back('{rd_req_mdata, rd_req_addr, cyc});
                else e_rd_ovf = 1;
            end
            if (wr_req_valid) begin
                if (wq.size() < QDEPTH) begin
                    wq.push_back('{wr_req_mdata, wr_req_addr, cyc});
                    mmem[wr_req_addr] = wr_req_data;
                end else begin
                    e_wr_ovf = 1;
                end
            end
            e_rd_af = (rq.size() >= QDEPTH - ALMFULL_SLACK);
            e_wr_af = (wq.size() >= QDEPTH - ALMFULL_SLACK);
        end
    end

    // Per-cycle comparison of every output against the model.
    bit mon_en = 0;
    int rd_total = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_rsp_valid", rd_rsp_valid, e_rd_v);
            check("rd_rsp_mdata", rd_rsp_mdata, e_rd_md);
            check("rd_rsp_data",  rd_rsp_data,  e_rd_d);
            check("wr_rsp_valid", wr_rsp_valid, e_wr_v);
            check("wr_rsp_mdata", wr_rsp_mdata, e_wr_md);
            check("rd_almfull",   rd_almfull,   e_rd_af);
            check("wr_almfull",   wr_almfull,   e_wr_af);
            check("rd_ovf",       rd_ovf,       e_rd_ovf);
            check("wr_ovf",       wr_ovf,       e_wr_ovf);
            if (rd_rsp_valid === 1'b1) rd_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        rd_req_valid = 0;
        wr_req_valid = 0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [DATA_W-1:0] pat_a5, one, rnd;
        bit honour;
        pat_a5 = {64{8'hA5}};
        one    = '0;
        one[0] = 1'b1;

        reset = 1; rsp_hold = 0;
        rd_req_valid = 0; rd_req_addr = '0; rd_req_mdata = '0;
        wr_req_valid = 0; wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
        tick();
        mon_en = 1;
        tick();
        @(negedge clk);
        check("rst_rd_valid", rd_rsp_valid, 0);
        check("rst_rd_data",  rd_rsp_data,  0);
        check("rst_almfull",  {rd_almfull, wr_almfull}, 0);
        #2;
        reset = 0;
        tick();

        // Give lines 0..15 known contents (zero).
        for (int a = 0; a < 16; a++) begin
            wr_req_valid = 1; wr_req_addr = ADDR_W'(a);
            wr_req_mdata = MDATA_W'(a); wr_req_data = '0;
            tick();
        end
        idle(12);

        // Write A5.. to line 3 (tag 7), then read it back (tag 9).
        wr_req_valid = 1; wr_req_addr = 3; wr_req_mdata = 7; wr_req_data = pat_a5;
        tick();
        wr_req_valid = 0;
        rd_req_valid = 1; rd_req_addr = 3; rd_req_mdata = 9;
        tick();
        rd_req_valid = 0;
        tick(); tick();
        @(negedge clk);
        check("t1_wr_ack_lat", wr_rsp_valid, 1);
        check("t1_wr_ack_tag", wr_rsp_mdata, 7);
        check("t1_rd_early",   rd_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_rd_lat",  rd_rsp_valid, 1);
        check("t1_rd_tag",  rd_rsp_mdata, 9);
        check("t1_rd_data", rd_rsp_data,  pat_a5);
        idle(8);

        // Eight back-to-back reads.
        base = rd_total;
        for (int i = 0; i < 8; i++) begin
            rd_req_valid = 1; rd_req_addr = ADDR_W'(i); rd_req_mdata = MDATA_W'(i);
            tick();
        end
        idle(12);
        check("t2_count", rd_total - base, 8);

        // Hold with 6 reads queued; wait past a stamp wrap, then release.
        rsp_hold = 1;
        tick();
        base = rd_total;
        for (int i = 0; i < 6; i++) begin
            rd_req_valid = 1; rd_req_addr = ADDR_W'(i); rd_req_mdata = MDATA_W'(16 + i);
            tick();
        end
        rd_req_valid = 0;
        @(negedge clk);
        check("t3_almfull", rd_almfull, 1);
        idle(24);
        check("t3_held", rd_total - base, 0);
        rsp_hold = 0;
        idle(10);
        check("t3_released", rd_total - base, 6);

        // Nine reads under hold: the ninth is dropped.
        rsp_hold = 1;
        tick();
        base = rd_total;
        for (int i = 0; i < 9; i++) begin
            rd_req_valid = 1; rd_req_addr = ADDR_W'(i); rd_req_mdata = MDATA_W'(32 + i);
            tick();
        end
        rd_req_valid = 0;
        @(negedge clk);
        check("t4_ovf_set", rd_ovf, 1);
        idle(5);
        rsp_hold = 0;
        idle(14);
        check("t4_count", rd_total - base, 8);
        check("t4_ovf_sticky", rd_ovf, 1);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("t4_ovf_cleared", rd_ovf, 0);
        idle(4);

        // Same-cycle write and pop on line 5: response carries the old value.
        rd_req_valid = 1; rd_req_addr = 5; rd_req_mdata = 50;
        tick();
        rd_req_valid = 0;
        tick(); tick();
        wr_req_valid = 1; wr_req_addr = 5; wr_req_mdata = 51; wr_req_data = one;
        tick();
        wr_req_valid = 0;
        @(negedge clk);
        check("t5_rbw_valid", rd_rsp_valid, 1);
        check("t5_rbw_old",   rd_rsp_data,  0);
        idle(8);
        rd_req_valid = 1; rd_req_addr = 5; rd_req_mdata = 52;
        tick();
        rd_req_valid = 0;
        tick(); tick(); tick();
        @(negedge clk);
        check("t5_new_valid", rd_rsp_valid, 1);
        check("t5_new_data",  rd_rsp_data,  one);
        idle(6);

        // Three reads then reset: none of them may ever respond.
        base = rd_total;
        for (int i = 0; i < 3; i++) begin
            rd_req_valid = 1; rd_req_addr = ADDR_W'(i); rd_req_mdata = MDATA_W'(60 + i);
            tick();
        end
        rd_req_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        idle(12);
        check("t6_no_rsp", rd_total - base, 0);
        rd_req_valid = 1; rd_req_addr = 3; rd_req_mdata = 70;
        tick();
        rd_req_valid = 0;
        tick(); tick(); tick();
        @(negedge clk);
        check("t6_mem_kept", rd_rsp_data, pat_a5);
        idle(4);

        // Randomized traffic on lines 0..15.
        for (int c = 0; c < 1200; c++) begin
            if (c % 200 == 0) honour = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) rsp_hold = ~rsp_hold;
            reset = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < DATA_W / 32; k++) rnd[k*32 +: 32] = $urandom;
            rd_req_valid = !reset && ($urandom_range(0, 2) != 0) && !(honour && rd_almfull);
            rd_req_addr  = ADDR_W'($urandom_range(0, 15));
            rd_req_mdata = MDATA_W'($urandom);
            wr_req_valid = !reset && ($urandom_range(0, 2) != 0) && !(honour && wr_almfull);
            wr_req_addr  = ADDR_W'($urandom_range(0, 15));
            wr_req_mdata = MDATA_W'($urandom);
            wr_req_data  = rnd;
            tick();
        end
        reset = 0;
        rsp_hold = 0;
        idle(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ccip_host_mem_responder.md
# ccip_host_mem_responder

Host-side memory responder for AFU bring-up benches: the far end of the CCI-P-style request/response channels that AFU harnesses drive. It accepts line-granular read requests (c0Tx side) and write requests (c1Tx side), holds a small line-addressed backing memory, and returns in-order read responses and write acks after a fixed minimum latency. It signals almost-full back-pressure, supports response stalling to exercise AFU wait paths, and flags overflow. It replaces the host model in unit-level AFU simulations.

## Interface
Parameters:
- ADDR_W, 8, line address width; memory depth is 2^ADDR_W lines
- DATA_W, 512, cache-line width in bits
- MDATA_W, 16, request tag width, echoed in responses
- LATENCY, 4, minimum request-to-response cycles; must be ≥ 2
- QDEPTH, 8, entries per response queue; power of 2
- ALMFULL_SLACK, 2, almost-full asserts when occupancy ≥ QDEPTH − ALMFULL_SLACK

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_req_valid  in  1  read request strobe, one per cycle max
- rd_req_addr  in  ADDR_W  line address
- rd_req_mdata  in  MDATA_W  read tag
- wr_req_valid  in  1  write request strobe
- wr_req_addr  in  ADDR_W  line address
- wr_req_mdata  in  MDATA_W  write tag
- wr_req_data  in  DATA_W  line data
- rsp_hold  in  1  when high, no responses are emitted on either channel
- rd_almfull  out  1  read queue almost full, registered
- wr_almfull  out  1  write-ack queue almost full, registered
- rd_rsp_valid  out  1  read response strobe
- rd_rsp_mdata  out  MDATA_W  echoed read tag
- rd_rsp_data  out  DATA_W  line data
- wr_rsp_valid  out  1  write ack strobe
- wr_rsp_mdata  out  MDATA_W  echoed write tag
- rd_ovf  out  1  sticky: a read request was dropped
- wr_ovf  out  1  sticky: a write request was dropped

## Operation
- Free-running cycle stamp counter; each accepted request is enqueued with {mdata, addr, stamp}.
- Read channel: FIFO of QDEPTH. The head is eligible when the current stamp minus the entry stamp is ≥ LATENCY − 1 (modular arithmetic; stamp width is ≥ clog2(LATENCY) + 2). If the head is eligible and rsp_hold is low, it is popped and memory is read. The response is registered and appears the following cycle with the tag and data.
- Memory read is read-before-write: a write accepted in the same cycle as a pop to the same address is not visible in that response. A write accepted in any earlier cycle is visible.
- Write channel: memory is updated at the acceptance edge. The ack entry is enqueued and popped under the same eligibility and rsp_hold rules. wr_rsp_valid carries the tag only.
- Responses are in-order per channel, at most one per channel per cycle. Both channels may respond in the same cycle.
- Push and pop in the same cycle on a full queue are legal; occupancy is unchanged.
- Overflow: a request arriving while its queue is full (with no pop that cycle) is dropped. A dropped write does not update memory. No response is generated, and the matching rd_ovf or wr_ovf is set.
- Almfull is a registered compare of next occupancy against QDEPTH − ALMFULL_SLACK.
- Reset: queues are flushed and in-flight responses discarded. The stamp counter and the ovf flags are cleared. Memory contents are not reset; reads of never-written lines return X in simulation.

## Timing
- Reset values: all *_valid = 0, *_almfull = 0, *_ovf = 0; mdata and data outputs = 0.
- With rsp_hold low and the queue empty, a request at cycle t gives a response valid at cycle t + LATENCY. Back-to-back requests give back-to-back responses.
- With rsp_hold high from cycle h, no valid is asserted from cycle h + 1. After release at cycle r, queued responses stream out one per cycle starting at r + 1.
- Almfull reflects the occupancy of the previous edge, so it lags by 1 cycle. Requesters honouring almfull lose nothing given ALMFULL_SLACK ≥ 2.
- Reset asserted mid-stream: valid outputs are 0 in the cycle after the reset edge. Responses to pre-reset requests never appear.

## Test plan
- Write 0xA5…A5 to addr 3 with tag 7, then read addr 3 with tag 9 (LATENCY = 4) -> wr_rsp_valid with mdata 7 at t+4; rd_rsp_valid with mdata 9 and data 0xA5…A5 exactly 4 cycles after the read.
- 8 consecutive reads of addrs 0–7 with tags 0–7 -> 8 consecutive responses, tags 0–7 in order, first at t+4.
- rsp_hold high, 6 reads issued -> no responses; rd_almfull = 1 after the 6th push is registered (QDEPTH 8, slack 2). Release hold -> 6 back-to-back responses.
- rsp_hold high, 9 reads -> 9th dropped and rd_ovf = 1. Release -> exactly 8 responses; rd_ovf stays 1 until reset.
- Same-cycle write of 0x1 to addr 5 and read-response pop of addr 5 (old value 0x0) -> response data 0x0; a subsequent read returns 0x1.
- 3 reads issued, then reset 2 cycles later -> no rd_rsp_valid ever; memory written before reset is still readable after.
